// File: rtl/rf_wport_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package rf_wport_arb_pkg;
  localparam int DATA_W           = 32;
  localparam int REG_W            = 5;
  localparam int CNT_W            = 4;
  localparam int FORCE_CNT_W      = 16;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } arbState_t;
endpackage

// File: rtl/rf_wport_arb_if.sv
// Write-port bundle: pipeline writeback request, long-latency handshake, register-file port.
interface rf_wport_arb_if;
  import rf_wport_arb_pkg::*;

  logic              PipeWrEn_i;
  logic [REG_W-1:0]  PipeWrReg_i;
  logic [DATA_W-1:0] PipeWrData_i;
  logic              LlValid_i;
  logic [REG_W-1:0]  LlWrReg_i;
  logic [DATA_W-1:0] LlWrData_i;
  logic              LlReady_o;
  logic              StallPipe_o;
  logic              RegWrEn_o;
  logic [REG_W-1:0]  WriteReg_o;
  logic [DATA_W-1:0] WriteData_o;

  modport master (
    output PipeWrEn_i, PipeWrReg_i, PipeWrData_i, LlValid_i, LlWrReg_i, LlWrData_i,
    input  LlReady_o, StallPipe_o, RegWrEn_o, WriteReg_o, WriteData_o
  );

  modport slave (
    input  PipeWrEn_i, PipeWrReg_i, PipeWrData_i, LlValid_i, LlWrReg_i, LlWrData_i,
    output LlReady_o, StallPipe_o, RegWrEn_o, WriteReg_o, WriteData_o
  );
endinterface

// File: rtl/rf_wport_arb.sv
// Register-file write-port arbiter: pipeline priority, optional starvation protection
// for the long-latency unit enabled by macro RF_ARB_STARVE_EN.
module rf_wport_arb
  import rf_wport_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  rf_wport_arb_if.slave          bus
`ifdef RF_ARB_STARVE_EN
  ,
  output logic [FORCE_CNT_W-1:0] ForceCnt_o
`endif
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : gBadLimit
    $error("rf_wport_arb: STARVE_LIMIT must lie in 1..15");
  end

  arbState_t state;
  logic      inForce;
  logic      pipeReq;
  logic      llReq;
  logic      llNull;
  logic      grantPipe;
  logic      grantLl;

  assign inForce = (state == FORCE);

  // Grant and output mux stay combinational so same-cycle forwarding still works.
  always_comb begin
    pipeReq   = bus.PipeWrEn_i && (bus.PipeWrReg_i != '0);
    llReq     = bus.LlValid_i  && (bus.LlWrReg_i   != '0);
    llNull    = bus.LlValid_i  && (bus.LlWrReg_i   == '0);
    grantPipe = pipeReq && !inForce;
    grantLl   = llReq && !grantPipe;
    bus.RegWrEn_o   = !rst_i && (grantPipe || grantLl);
    bus.LlReady_o   = !rst_i && (grantLl || llNull);
    bus.WriteReg_o  = grantLl ? bus.LlWrReg_i  : bus.PipeWrReg_i;
    bus.WriteData_o = grantLl ? bus.LlWrData_i : bus.PipeWrData_i;
  end

`ifdef RF_ARB_STARVE_EN
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]       waitCnt;
  logic                   stallQ;
  logic [FORCE_CNT_W-1:0] forceCnt;
  logic                   blocked;

  function automatic logic [FORCE_CNT_W-1:0] satInc(input logic [FORCE_CNT_W-1:0] v);
    return (&v) ? v : v + FORCE_CNT_W'(1);
  endfunction

  assign blocked = llReq && grantPipe;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      waitCnt  <= '0;
      stallQ   <= 1'b0;
      forceCnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (blocked) begin
            state   <= WAIT;
            waitCnt <= CNT_ONE;
          end
        end
        WAIT: begin
          // Leaving "blocked" covers a grant, LlValid_i dropping and a null request.
          if (!blocked) begin
            state   <= IDLE;
            waitCnt <= '0;
          end else if (waitCnt == LIMIT) begin
            state    <= FORCE;
            waitCnt  <= '0;
            stallQ   <= 1'b1;
            forceCnt <= satInc(forceCnt);
          end else begin
            waitCnt <= waitCnt + CNT_ONE;
          end
        end
        FORCE: begin
          state  <= IDLE;
          stallQ <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          waitCnt <= '0;
          stallQ  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.StallPipe_o = stallQ;
  assign ForceCnt_o      = forceCnt;
`else
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= IDLE;
  end

  assign bus.StallPipe_o = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wport_arb.sv
// Scoreboard bench for rf_wport_arb; covers the starvation path when RF_ARB_STARVE_EN is defined.
module tb_rf_wport_arb;
  import rf_wport_arb_pkg::*;

  typedef struct {
    string       name;
    logic        wrEn;
    logic [4:0]  wrReg;
    logic [31:0] wrData;
    logic        llReady;
    logic        stall;
  } exp_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t expQ[$];

  rf_wport_arb_if bus();
`ifdef RF_ARB_STARVE_EN
  logic [15:0] forceCnt;
`endif

  rf_wport_arb #(.STARVE_LIMIT(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
`ifdef RF_ARB_STARVE_EN
    ,
    .ForceCnt_o (forceCnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic drive(input logic pe, input logic [4:0] pr, input logic [31:0] pd,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ld);
    bus.PipeWrEn_i   = pe;
    bus.PipeWrReg_i  = pr;
    bus.PipeWrData_i = pd;
    bus.LlValid_i    = lv;
    bus.LlWrReg_i    = lr;
    bus.LlWrData_i   = ld;
  endtask

  task automatic vec(input string name,
                     input logic pe, input logic [4:0] pr, input logic [31:0] pd,
                     input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                     input logic ew, input logic [4:0] er, input logic [31:0] ed,
                     input logic ell, input logic est);
    exp_t e;
    @(posedge clk);
    #1;
    drive(pe, pr, pd, lv, lr, ld);
    e.name = name; e.wrEn = ew; e.wrReg = er; e.wrData = ed; e.llReady = ell; e.stall = est;
    expQ.push_back(e);
  endtask

  // Monitor: compares the presented write port against the oldest expectation.
  initial begin
    exp_t e;
    bit   ok;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checks++;
        ok = (bus.RegWrEn_o === e.wrEn) && (bus.LlReady_o === e.llReady) &&
             (bus.StallPipe_o === e.stall) &&
             (!e.wrEn || ((bus.WriteReg_o === e.wrReg) && (bus.WriteData_o === e.wrData)));
        if (!ok) begin
          errors++;
          $display("FAIL %s: got en=%b reg=%0d data=0x%0h rdy=%b stall=%b expected en=%b reg=%0d data=0x%0h rdy=%b stall=%b",
                   e.name, bus.RegWrEn_o, bus.WriteReg_o, bus.WriteData_o, bus.LlReady_o,
                   bus.StallPipe_o, e.wrEn, e.wrReg, e.wrData, e.llReady, e.stall);
        end
        checks++;
        if (bus.RegWrEn_o === 1'b1 && bus.WriteReg_o === 5'd0) begin
          errors++;
          $display("FAIL %s_x0_write: got en=1 reg=0 expected no write to x0", e.name);
        end
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
    if (expQ.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", expQ.size());
      expQ.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22);
    #3;
    chk("rst_regwren", 32'(bus.RegWrEn_o), 32'd0);
    chk("rst_llready", 32'(bus.LlReady_o), 32'd0);
    chk("rst_stall", 32'(bus.StallPipe_o), 32'd0);
`ifdef RF_ARB_STARVE_EN
    chk("rst_forcecnt", 32'(forceCnt), 32'd0);
`endif
    #4;
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    vec("pipe_over_ll",  1, 5, 32'h11, 1, 6, 32'h22,   1, 5, 32'h11,   0, 0);
    vec("ll_after_pipe", 0, 0, 32'h0,  1, 6, 32'h22,   1, 6, 32'h22,   1, 0);
    vec("pipe_x0_ll_x3", 1, 0, 32'h55, 1, 3, 32'hABCD, 1, 3, 32'hABCD, 1, 0);
    vec("ll_x0_pipe_x9", 1, 9, 32'h99, 1, 0, 32'hDEAD, 1, 9, 32'h99,   1, 0);
    vec("both_null",     1, 0, 32'h1,  1, 0, 32'h2,    0, 0, 32'h0,    1, 0);
    vec("idle",          0, 0, 32'h0,  0, 0, 32'h0,    0, 0, 32'h0,    0, 0);

`ifdef RF_ARB_STARVE_EN
    for (int i = 0; i < 5; i++)
      vec("starve_wait", 1, 5'(10 + i), 32'h100 + i, 1, 7, 32'h77, 1, 5'(10 + i), 32'h100 + i, 0, 0);
    vec("force_grant", 1, 14, 32'h104, 1, 7, 32'h77, 1, 7,  32'h77,  1, 1);
    vec("after_force", 1, 14, 32'h104, 0, 0, 32'h0,  1, 14, 32'h104, 0, 0);
    drain();
    chk("forcecnt_1", 32'(forceCnt), 32'd1);

    for (int i = 0; i < 5; i++)
      vec("starve_wait2", 1, 15, 32'h5, 1, 8, 32'h88, 1, 15, 32'h5, 0, 0);
    vec("force_ll_drop", 1, 15, 32'h5, 0, 0, 32'h0, 0, 0, 32'h0, 0, 1);
    vec("after_drop",    0, 0,  32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
    drain();
    chk("forcecnt_2", 32'(forceCnt), 32'd2);

    for (int i = 0; i < 5; i++)
      vec("starve_wait3", 1, 12, 32'h12, 1, 9, 32'h99, 1, 12, 32'h12, 0, 0);
    vec("force_pre_rst", 1, 12, 32'h12, 1, 9, 32'h99, 1, 9, 32'h99, 1, 1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midforce_rst_stall", 32'(bus.StallPipe_o), 32'd0);
    chk("midforce_rst_forcecnt", 32'(forceCnt), 32'd0);
    chk("midforce_rst_regwren", 32'(bus.RegWrEn_o), 32'd0);
    chk("midforce_rst_llready", 32'(bus.LlReady_o), 32'd0);
    #1;
    rst = 1'b0;
    vec("post_rst_block", 1, 12, 32'h12, 1, 9, 32'h99, 1, 12, 32'h12, 0, 0);
    vec("post_rst_grant", 0, 0,  32'h0,  1, 9, 32'h99, 1, 9,  32'h99, 1, 0);
    vec("post_rst_idle",  0, 0,  32'h0,  0, 0, 32'h0,  0, 0,  32'h0,  0, 0);
`else
    for (int i = 0; i < 20; i++)
      vec("nostarve_pipe", 1, 5'(1 + i), 32'(i), 1, 7, 32'h77, 1, 5'(1 + i), 32'(i), 0, 0);
    vec("nostarve_grant", 0, 0, 32'h0, 1, 7, 32'h77, 1, 7, 32'h77, 1, 0);
    vec("nostarve_idle",  0, 0, 32'h0, 0, 0, 32'h0,  0, 0, 32'h0,  0, 0);
`endif
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
